// File: rtl/myocontrol_pkg.sv
// Shared definitions for the myocontrol SPI slave: FSM state type, parameter
// defaults and the levels the input synchronizers hold while the bus is idle.
package myocontrol_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_SHIFT = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int WORD_BITS_DEF   = 16;
   localparam int FRAME_WORDS_DEF = 12;

   localparam logic SCK_IDLE  = 1'b0;
   localparam logic SS_N_IDLE = 1'b1;
   localparam logic MOSI_IDLE = 1'b0;

endpackage : myocontrol_pkg

// File: rtl/myocontrol_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with single-cycle
// rise/fall strobes derived from the synchronized level.
module myocontrol_sync_edge #(
   parameter int   STAGES     = 2,
   parameter logic IDLE_LEVEL = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic async_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [STAGES-1:0] sync_q;
   logic              prev_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         sync_q <= {STAGES{IDLE_LEVEL}};
         prev_q <= IDLE_LEVEL;
      end else begin
         sync_q <= (sync_q << 1) | STAGES'(async_i);
         prev_q <= sync_q[STAGES-1];
      end
   end

   // Strobes are combinational so the consumer acts one cycle sooner, which
   // keeps miso inside the half sck period at the minimum clock ratio.
   assign level_o = sync_q[STAGES-1];
   assign rise_o  = sync_q[STAGES-1] & ~prev_q;
   assign fall_o  = ~sync_q[STAGES-1] & prev_q;

endmodule : myocontrol_sync_edge

// File: rtl/myocontrol_spi_slave.sv
// SPI mode-1 (CPOL=0, CPHA=1, MSB first) slave for the myocontrol bus, framed by ss_n.
// Define MYOCONTROL_SLAVE_FRAME_CHECK_EN to flag frames whose word count differs from FRAME_WORDS.
module myocontrol_spi_slave
   import myocontrol_pkg::*;
#(
   parameter int WORD_BITS   = WORD_BITS_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int FRAME_WORDS = FRAME_WORDS_DEF
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 sck,
   input  logic                 ss_n,
   input  logic                 mosi,
   output logic                 miso,
   output logic                 miso_oe,
   output logic [WORD_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic [WORD_BITS-1:0] tx_data,
   output logic                 tx_load,
   output logic                 frame_active,
   output logic                 frame_done,
   output logic                 frame_error,
   output logic [7:0]           word_count
);

   localparam int              CNT_W    = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_BITS - 1);

`ifdef MYOCONTROL_SLAVE_FRAME_CHECK_EN
   localparam bit FRAME_CHECK_EN = 1'b1;
`else
   localparam bit FRAME_CHECK_EN = 1'b0;
`endif

   logic sck_rise, sck_fall;
   logic ss_rise, ss_fall, ss_level;
   logic mosi_s;

   myocontrol_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(SCK_IDLE)) u_sync_sck (
      .clock(clock), .reset(reset), .async_i(sck),
      .level_o(), .rise_o(sck_rise), .fall_o(sck_fall)
   );

   myocontrol_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(SS_N_IDLE)) u_sync_ss_n (
      .clock(clock), .reset(reset), .async_i(ss_n),
      .level_o(ss_level), .rise_o(ss_rise), .fall_o(ss_fall)
   );

   myocontrol_sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(MOSI_IDLE)) u_sync_mosi (
      .clock(clock), .reset(reset), .async_i(mosi),
      .level_o(mosi_s), .rise_o(), .fall_o()
   );

   state_e               state_q;
   logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
   logic [7:0]           word_count_q, word_count_d;
   logic [WORD_BITS-1:0] tx_shift_q, rx_shift_q, rx_data_q, rx_word;
   logic                 miso_q, rx_valid_q, tx_load_q, frame_active_q;
   logic                 frame_done_q, frame_error_q;
   logic                 word_end;

   assign rx_word = {rx_shift_q[WORD_BITS-2:0], mosi_s};

   // Counters after this cycle's sck edge; the ss_n decision looks at these
   // so a simultaneous final edge and deselect still ends the frame cleanly.
   always_comb begin
      // NOTE: every signal gets a default first so no latch can be inferred.
      word_end     = (state_q == ST_SHIFT) && sck_fall && (bit_cnt_q == LAST_BIT);
      bit_cnt_d    = bit_cnt_q;
      word_count_d = word_count_q;
      if ((state_q == ST_SHIFT) && sck_fall) begin
         bit_cnt_d = word_end ? '0 : bit_cnt_q + 1'b1;
      end
      if (word_end && (word_count_q != 8'hFF)) begin
         word_count_d = word_count_q + 8'd1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         bit_cnt_q      <= '0;
         word_count_q   <= '0;
         tx_shift_q     <= '0;
         rx_shift_q     <= '0;
         rx_data_q      <= '0;
         miso_q         <= 1'b0;
         rx_valid_q     <= 1'b0;
         tx_load_q      <= 1'b0;
         frame_active_q <= 1'b0;
         frame_done_q   <= 1'b0;
         frame_error_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking throughout, so every branch reads pre-edge values.
         rx_valid_q    <= 1'b0;
         tx_load_q     <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_error_q <= 1'b0;

         unique case (state_q)
            ST_IDLE: begin
               miso_q <= 1'b0;
               if (ss_fall) begin
                  state_q        <= ST_LOAD;
                  frame_active_q <= 1'b1;
                  tx_load_q      <= 1'b1;
               end
            end

            ST_LOAD: begin
               tx_shift_q   <= tx_data;
               bit_cnt_q    <= '0;
               word_count_q <= '0;
               state_q      <= ST_SHIFT;
            end

            ST_SHIFT: begin
               if (sck_rise) begin
                  miso_q     <= tx_shift_q[WORD_BITS-1];
                  tx_shift_q <= tx_shift_q << 1;
               end
               if (sck_fall) begin
                  rx_shift_q <= rx_word;
               end
               if (word_end) begin
                  rx_data_q  <= rx_word;
                  rx_valid_q <= 1'b1;
                  tx_load_q  <= 1'b1;
                  tx_shift_q <= tx_data;
               end
               bit_cnt_q    <= bit_cnt_d;
               word_count_q <= word_count_d;

               if (ss_rise && ss_level) begin
                  frame_active_q <= 1'b0;
                  miso_q         <= 1'b0;
                  if (bit_cnt_d == '0) begin
                     state_q       <= ST_DONE;
                     frame_done_q  <= 1'b1;
                     frame_error_q <= FRAME_CHECK_EN && (word_count_d != 8'(FRAME_WORDS));
                  end else begin
                     state_q       <= ST_IDLE;
                     frame_error_q <= 1'b1;
                  end
               end
            end

            ST_DONE: state_q <= ST_IDLE;

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign miso         = miso_q;
   assign miso_oe      = frame_active_q;
   assign rx_data      = rx_data_q;
   assign rx_valid     = rx_valid_q;
   assign tx_load      = tx_load_q;
   assign frame_active = frame_active_q;
   assign frame_done   = frame_done_q;
   assign frame_error  = frame_error_q;
   assign word_count   = word_count_q;

endmodule : myocontrol_spi_slave

// File: tb/tb_myocontrol_spi_slave.sv
// Bench for myocontrol_spi_slave: a bit-level SPI mode-1 master with random words,
// and a frame-level tally model of the pulses and word counts each frame should produce.
module tb_myocontrol_spi_slave;

   localparam int WB      = 16;
   localparam int FRAME_W = 12;
   localparam int HALF    = 40;   // sck half period: sck = clock/8

`ifdef MYOCONTROL_SLAVE_FRAME_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          sck   = 1'b0;
   logic          ss_n  = 1'b1;
   logic          mosi  = 1'b0;
   logic          miso, miso_oe, rx_valid, tx_load;
   logic          frame_active, frame_done, frame_error;
   logic [WB-1:0] rx_data;
   logic [WB-1:0] tx_data = '0;
   logic [7:0]    word_count;

   myocontrol_spi_slave dut (
      .clock(clock), .reset(reset), .sck(sck), .ss_n(ss_n), .mosi(mosi),
      .miso(miso), .miso_oe(miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
      .tx_data(tx_data), .tx_load(tx_load), .frame_active(frame_active),
      .frame_done(frame_done), .frame_error(frame_error), .word_count(word_count)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Monitor: pulse tallies and captured rx words, sampled on the falling clock edge.
   int            n_rx = 0, n_txl = 0, n_done = 0, n_err = 0, n_both = 0;
   int            n_miso_idle = 0, n_oe_bad = 0;
   logic [WB-1:0] got_rx [256];

   always @(negedge clock) begin
      if (rx_valid === 1'b1) begin
         got_rx[n_rx % 256] = rx_data;
         n_rx++;
      end
      if (tx_load === 1'b1)     n_txl++;
      if (frame_done === 1'b1)  n_done++;
      if (frame_error === 1'b1) n_err++;
      if (frame_done === 1'b1 && frame_error === 1'b1) n_both++;
      if (frame_active === 1'b0 && miso !== 1'b0) n_miso_idle++;
      if (!reset && miso_oe !== frame_active)     n_oe_bad++;
   end

   // Frame-level expectation model
   logic [WB-1:0] exp_rx[$];
   int e_rx = 0, e_txl = 0, e_done = 0, e_err = 0, e_both = 0, e_wc = 0;
   int b_rx = 0, b_txl = 0, b_done = 0, b_err = 0, b_both = 0;

   task automatic model_frame(input int n_bits, input bit cut_by_reset);
      int words, part;
      words  = n_bits / WB;
      part   = n_bits % WB;
      e_rx  += words;
      e_txl += words + 1;
      if (cut_by_reset) begin
         e_wc = 0;
      end else if (part != 0) begin
         e_err++;
         e_wc = (words > 255) ? 255 : words;
      end else begin
         e_done++;
         e_wc = (words > 255) ? 255 : words;
         if (CHK && words != FRAME_W) begin
            e_err++;
            e_both++;
         end
      end
   endtask

   task automatic verify(input string tag);
      int k;
      repeat (12) @(posedge clock);
      @(negedge clock);
      check({tag, " rx_valid pulses"}, n_rx - b_rx, e_rx);
      check({tag, " tx_load pulses"}, n_txl - b_txl, e_txl);
      check({tag, " frame_done pulses"}, n_done - b_done, e_done);
      check({tag, " frame_error pulses"}, n_err - b_err, e_err);
      check({tag, " done+error same cycle"}, n_both - b_both, e_both);
      check({tag, " word_count"}, word_count, e_wc);
      check({tag, " idle frame_active"}, frame_active, 0);
      check({tag, " idle miso_oe"}, miso_oe, 0);
      k = (n_rx - b_rx < exp_rx.size()) ? n_rx - b_rx : exp_rx.size();
      for (int i = 0; i < k; i++) begin
         check({tag, " rx_data"}, got_rx[(b_rx + i) % 256], exp_rx[i]);
      end
      exp_rx.delete();
      b_rx = n_rx; b_txl = n_txl; b_done = n_done; b_err = n_err; b_both = n_both;
      e_rx = 0; e_txl = 0; e_done = 0; e_err = 0; e_both = 0;
   endtask

   // Mode-1 master: drive mosi on sck rise, sample miso on sck fall.
   task automatic spi_frame(input int n_bits, input bit fixed, input logic [WB-1:0] fixed_word,
                            input bit close);
      logic [WB-1:0] w, rd;
      w  = '0;
      rd = '0;
      @(posedge clock);
      #3;
      ss_n = 1'b0;
      #(2 * HALF);
      for (int i = 0; i < n_bits; i++) begin
         int b;
         b = WB - 1 - (i % WB);
         if (b == WB - 1) w = fixed ? fixed_word : WB'($urandom);
         sck  = 1'b1;
         mosi = w[b];
         #HALF;
         sck   = 1'b0;
         rd[b] = miso;
         #HALF;
         if (b == 0) begin
            exp_rx.push_back(w);
            check("miso word read by master", rd, tx_data);
         end
      end
      if (close) begin
         #HALF;
         ss_n = 1'b1;
         mosi = 1'b0;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   initial begin
      int nw, extra, bits;
      repeat (4) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("reset miso", miso, 0);
      check("reset miso_oe", miso_oe, 0);
      check("reset rx_data", rx_data, 0);
      check("reset rx_valid", rx_valid, 0);
      check("reset tx_load", tx_load, 0);
      check("reset frame_active", frame_active, 0);
      check("reset word_count", word_count, 0);
      check("reset frame_done/error", {frame_done, frame_error}, 0);

      // Full 12-word frame with fixed patterns
      tx_data = 16'hA5C3;
      spi_frame(12 * WB, 1'b1, 16'h1234, 1'b1);
      model_frame(12 * WB, 1'b0);
      verify("full frame");

      // sck activity while deselected
      for (int i = 0; i < 100; i++) begin
         sck  = ~sck;
         mosi = 1'($urandom);
         #HALF;
      end
      sck  = 1'b0;
      mosi = 1'b0;
      verify("sck while deselected");

      // Abort after 7 bits of word 3
      tx_data = WB'($urandom);
      spi_frame(2 * WB + 7, 1'b0, '0, 1'b1);
      model_frame(2 * WB + 7, 1'b0);
      verify("aborted frame");

      // Short 5-word frame
      tx_data = WB'($urandom);
      spi_frame(5 * WB, 1'b0, '0, 1'b1);
      model_frame(5 * WB, 1'b0);
      verify("short frame");

      // Reset after 20 bits, then a clean full frame
      tx_data = WB'($urandom);
      spi_frame(20, 1'b0, '0, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("mid-frame reset outputs",
            {miso, miso_oe, rx_valid, tx_load, frame_active, frame_done, frame_error}, 0);
      check("mid-frame reset rx_data", rx_data, 0);
      check("mid-frame reset word_count", word_count, 0);
      ss_n = 1'b1;
      sck  = 1'b0;
      mosi = 1'b0;
      repeat (4) @(negedge clock);
      reset = 1'b0;
      model_frame(20, 1'b1);
      verify("reset cut frame");
      tx_data = 16'hA5C3;
      spi_frame(12 * WB, 1'b1, 16'h1234, 1'b1);
      model_frame(12 * WB, 1'b0);
      verify("frame after reset");

      // Back-to-back frames, 4 clock cycles of ss_n high between them
      tx_data = WB'($urandom);
      nw = $urandom_range(1, 4);
      spi_frame(nw * WB, 1'b0, '0, 1'b1);
      model_frame(nw * WB, 1'b0);
      #(4 * 10 - 3);
      tx_data = WB'($urandom);
      nw = $urandom_range(1, 4);
      spi_frame(nw * WB, 1'b0, '0, 1'b1);
      model_frame(nw * WB, 1'b0);
      verify("back-to-back frames");

      // Random frame lengths, some aborted mid-word
      for (int f = 0; f < 4; f++) begin
         tx_data = WB'($urandom);
         nw      = $urandom_range(1, 14);
         extra   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, WB - 1) : 0;
         bits    = nw * WB + extra;
         spi_frame(bits, 1'b0, '0, 1'b1);
         model_frame(bits, 1'b0);
         verify("random frame");
      end

      check("miso high while inactive (count)", n_miso_idle, 0);
      check("miso_oe differs from frame_active (count)", n_oe_bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule : tb_myocontrol_spi_slave
